// File: rtl/sa_drain_ctrl_if.sv
// Handshake and data bundle between the systolic-array drain controller and its environment.
// master = drain controller side, slave = array / result-buffer side.
interface sa_drain_ctrl_if #(
    parameter int Y      = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic                  cal_done;
    logic [Y*DATA_W-1:0]   south_data;
    logic                  out_ready;
    logic                  err_clr;
    logic                  shift_en;
    logic                  out_wr_en;
    logic [ADDR_W-1:0]     out_addr;
    logic [Y*DATA_W-1:0]   out_data;
    logic                  drain_done;
    logic                  busy;
    logic                  overrun;

    modport master (
        input  cal_done, south_data, out_ready, err_clr,
        output shift_en, out_wr_en, out_addr, out_data, drain_done, busy, overrun
    );

    modport slave (
        output cal_done, south_data, out_ready, err_clr,
        input  shift_en, out_wr_en, out_addr, out_data, drain_done, busy, overrun
    );
endinterface

// File: rtl/sa_drain_ctrl.sv
// Drains X rows of PE results southward out of the systolic array into the result buffer.
// Latency: first row write 2 cycles after cal_done; one row per out_ready cycle.
// Backpressure: out_ready low stalls both the array shift and the write; nothing is dropped.
module sa_drain_ctrl #(
    parameter int X      = 3,
    parameter int Y      = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            sys_rst_n,
    sa_drain_ctrl_if.master io
);
    localparam int               CNT_W    = $clog2(X + 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(X - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      row_cnt;
    logic                  last_row;
    logic                  take_row;
    logic                  shift_en_c;
    logic                  ovr_set;

    logic                  out_wr_en_q;
    logic [ADDR_W-1:0]     out_addr_q;
    logic [Y*DATA_W-1:0]   out_data_q;
    logic                  drain_done_q;
    logic                  busy_q;
    logic                  overrun_q;

    assign last_row = (row_cnt == LAST_ROW);
    assign take_row = (state == DRAIN) && io.out_ready;
    // busy is high for the whole drain, including its final cycle, so a
    // cal_done on the returning edge is also flagged.
    assign ovr_set  = io.cal_done && busy_q;

    always_comb begin
        state_nxt  = state;
        shift_en_c = 1'b0;
        case (state)
            IDLE: begin
                if (io.cal_done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                shift_en_c = io.out_ready;
                if (io.out_ready && last_row) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            row_cnt <= '0;
        end else if ((state == IDLE) && io.cal_done) begin
            row_cnt <= '0;
        end else if (take_row) begin
            // wrap at the last row so the counter never leaves 0..X-1
            row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_wr_en_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            drain_done_q <= 1'b0;
        end else begin
            out_wr_en_q  <= take_row;
            drain_done_q <= take_row && last_row;
            if (take_row) begin
                // bottom PE row leaves the array first, so addresses count down
                out_addr_q <= ADDR_W'(LAST_ROW - row_cnt);
                out_data_q <= io.south_data;
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == DRAIN);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            overrun_q <= 1'b0;
        end else if (ovr_set) begin
            overrun_q <= 1'b1;
        end else if (io.err_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign io.shift_en   = shift_en_c;
    assign io.out_wr_en  = out_wr_en_q;
    assign io.out_addr   = out_addr_q;
    assign io.out_data   = out_data_q;
    assign io.drain_done = drain_done_q;
    assign io.busy       = busy_q;
    assign io.overrun    = overrun_q;
endmodule

// File: tb/tb_sa_drain_ctrl.sv
// Self-checking bench for sa_drain_ctrl: behavioural array model plus a scoreboard of expected row writes.
module tb_sa_drain_ctrl;
    localparam int X      = 3;
    localparam int Y      = 3;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef struct {
        logic [ADDR_W-1:0]   addr;
        logic [Y*DATA_W-1:0] data;
        logic                last;
    } exp_t;

    logic clk;
    logic sys_rst_n;
    logic [Y*DATA_W-1:0] arr [X];
    exp_t sb [$];
    int   n_tests;
    int   n_fail;
    logic [5:0] rdy_pat;

    sa_drain_ctrl_if #(.Y(Y), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) io ();

    sa_drain_ctrl #(.X(X), .Y(Y), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .io        (io)
    );

    assign io.south_data = arr[X-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // row r, column c holds {seed, r+1, c}; bottom row is r = X-1
    task automatic load(input int seed);
        for (int r = 0; r < X; r++)
            for (int c = 0; c < Y; c++)
                arr[r][c*DATA_W +: DATA_W] = 16'((seed << 12) | ((r + 1) << 8) | c);
    endtask

    task automatic push_drain();
        exp_t e;
        for (int k = 0; k < X; k++) begin
            e.addr = ADDR_W'(X - 1 - k);
            e.data = arr[X-1-k];
            e.last = (k == X - 1);
            sb.push_back(e);
        end
    endtask

    // one clock; the array shifts south when the controller requested it
    task automatic cycle();
        logic sh;
        @(negedge clk);
        sh = io.shift_en;
        @(posedge clk);
        #1;
        if (sh) begin
            for (int r = X - 1; r > 0; r--) arr[r] = arr[r-1];
            arr[0] = '0;
        end
    endtask

    always @(negedge clk) begin
        if (sys_rst_n && io.out_wr_en) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", 64'(io.out_wr_en), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_addr", 64'(io.out_addr), 64'(e.addr));
                check("sb_data", 64'(io.out_data), 64'(e.data));
                check("sb_done", 64'(io.drain_done), 64'(e.last));
            end
        end else if (sys_rst_n && io.drain_done) begin
            check("done_without_wr", 64'(io.drain_done), 64'd0);
        end
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rdy_pat      = 6'b101001;
        sys_rst_n    = 1'b0;
        io.cal_done  = 1'b0;
        io.out_ready = 1'b0;
        io.err_clr   = 1'b0;
        load(0);
        #12;
        check("rst_wr",   64'(io.out_wr_en),  64'd0);
        check("rst_addr", 64'(io.out_addr),   64'd0);
        check("rst_data", 64'(io.out_data),   64'd0);
        check("rst_done", 64'(io.drain_done), 64'd0);
        check("rst_busy", 64'(io.busy),       64'd0);
        check("rst_ovr",  64'(io.overrun),    64'd0);
        check("rst_shift",64'(io.shift_en),   64'd0);
        @(posedge clk); #1;
        sys_rst_n = 1'b1;
        cycle();

        // basic drain with out_ready held high
        load(1);
        io.out_ready = 1'b1;
        io.cal_done  = 1'b1;
        push_drain();
        cycle();
        io.cal_done = 1'b0;
        check("t1_busy", 64'(io.busy), 64'd1);
        check("t1_wr_e1", 64'(io.out_wr_en), 64'd0);
        cycle();
        check("t1_wr_e2", 64'(io.out_wr_en), 64'd1);
        check("t1_addr2", 64'(io.out_addr), 64'd2);
        cycle();
        check("t1_wr_e3", 64'(io.out_wr_en), 64'd1);
        check("t1_addr1", 64'(io.out_addr), 64'd1);
        check("t1_nodone", 64'(io.drain_done), 64'd0);
        cycle();
        check("t1_wr_e4", 64'(io.out_wr_en), 64'd1);
        check("t1_addr0", 64'(io.out_addr), 64'd0);
        check("t1_done", 64'(io.drain_done), 64'd1);
        check("t1_busy_lo", 64'(io.busy), 64'd0);
        cycle();
        check("t1_wr_after", 64'(io.out_wr_en), 64'd0);
        check("t1_done_after", 64'(io.drain_done), 64'd0);

        // backpressure
        load(2);
        io.out_ready = 1'b0;
        io.cal_done  = 1'b1;
        push_drain();
        cycle();
        io.cal_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            io.out_ready = rdy_pat[i];
            #1;
            check("bp_shift", 64'(io.shift_en), 64'(rdy_pat[i]));
            cycle();
            check("bp_wr", 64'(io.out_wr_en), 64'(rdy_pat[i]));
            check("bp_done", 64'(io.drain_done), 64'(i == 5));
        end
        check("bp_busy_lo", 64'(io.busy), 64'd0);
        io.out_ready = 1'b1;
        cycle();

        // overrun during a drain, then clear, then clear racing a new event
        load(3);
        io.cal_done = 1'b1;
        push_drain();
        cycle();
        io.cal_done = 1'b0;
        cycle();
        io.cal_done = 1'b1;
        cycle();
        io.cal_done = 1'b0;
        check("ovr_set", 64'(io.overrun), 64'd1);
        cycle();
        check("ovr_drain_done", 64'(io.drain_done), 64'd1);
        cycle();
        check("ovr_sticky", 64'(io.overrun), 64'd1);
        io.err_clr = 1'b1;
        cycle();
        io.err_clr = 1'b0;
        check("ovr_cleared", 64'(io.overrun), 64'd0);
        load(4);
        io.cal_done = 1'b1;
        push_drain();
        cycle();
        io.err_clr = 1'b1;
        cycle();
        io.cal_done = 1'b0;
        io.err_clr  = 1'b0;
        check("ovr_set_wins", 64'(io.overrun), 64'd1);
        cycle();
        cycle();
        check("ovr2_done", 64'(io.drain_done), 64'd1);
        io.err_clr = 1'b1;
        cycle();
        io.err_clr = 1'b0;
        cycle();

        // cal_done on the final-write edge is an overrun; next cycle starts a drain
        load(5);
        io.cal_done = 1'b1;
        push_drain();
        cycle();
        io.cal_done = 1'b0;
        cycle();
        cycle();
        io.cal_done = 1'b1;
        cycle();
        check("b2b_done", 64'(io.drain_done), 64'd1);
        check("b2b_ovr", 64'(io.overrun), 64'd1);
        check("b2b_idle", 64'(io.busy), 64'd0);
        load(6);
        push_drain();
        cycle();
        io.cal_done = 1'b0;
        check("b2b_restart", 64'(io.busy), 64'd1);
        check("b2b_wr_e1", 64'(io.out_wr_en), 64'd0);
        cycle();
        cycle();
        cycle();
        check("b2b_done2", 64'(io.drain_done), 64'd1);
        check("b2b_addr0", 64'(io.out_addr), 64'd0);
        cycle();

        // reset in the middle of a drain
        load(7);
        io.cal_done = 1'b1;
        push_drain();
        cycle();
        io.cal_done = 1'b0;
        cycle();
        check("mid_wr1", 64'(io.out_wr_en), 64'd1);
        @(negedge clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_wr",   64'(io.out_wr_en),  64'd0);
        check("mid_rst_addr", 64'(io.out_addr),   64'd0);
        check("mid_rst_data", 64'(io.out_data),   64'd0);
        check("mid_rst_busy", 64'(io.busy),       64'd0);
        check("mid_rst_ovr",  64'(io.overrun),    64'd0);
        check("mid_rst_shift",64'(io.shift_en),   64'd0);
        sb.delete();
        cycle();
        cycle();
        sys_rst_n = 1'b1;
        cycle();
        load(8);
        io.cal_done = 1'b1;
        push_drain();
        cycle();
        io.cal_done = 1'b0;
        cycle();
        check("post_rst_addr2", 64'(io.out_addr), 64'd2);
        cycle();
        cycle();
        check("post_rst_done", 64'(io.drain_done), 64'd1);
        cycle();

        // idle with out_ready toggling must stay quiet
        for (int i = 0; i < 8; i++) begin
            io.out_ready = i[0];
            #1;
            check("idle_shift", 64'(io.shift_en), 64'd0);
            cycle();
            check("idle_wr", 64'(io.out_wr_en), 64'd0);
            check("idle_done", 64'(io.drain_done), 64'd0);
        end

        cycle();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sa_drain_ctrl.md
Name: sa_drain_ctrl

Overview:
- Output-side controller for the X-by-Y systolic array. It complements the input-side configuration block, which feeds west/north operands and pulses cal_done.
- On cal_done, it drains the accumulated PE results row by row, by shifting the array southward, and writes each row into the result buffer.
- Honours downstream backpressure and reports drain completion and overrun.

Parameters:
X, 3, number of PE rows (results drained per matrix = X rows)
Y, 3, number of PE columns (results per row)
DATA_W, 16, width of one PE accumulator result
ADDR_W, 4, result-buffer row address width; must satisfy 2^ADDR_W >= X

Ports:
clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
cal_done  input  1  one-cycle pulse from input-side controller: array results valid
south_data  input  Y*DATA_W  bottom-row results of array; column 0 in LSBs
out_ready  input  1  result buffer can accept a row this cycle
err_clr  input  1  clears overrun flag
shift_en  output  1  combinational; array shifts all rows down one place at this clock edge
out_wr_en  output  1  registered write strobe to result buffer
out_addr  output  ADDR_W  registered row address for write
out_data  output  Y*DATA_W  registered row data for write
drain_done  output  1  registered one-cycle pulse, coincident with final out_wr_en
busy  output  1  registered; high while not IDLE
overrun  output  1  sticky: cal_done arrived while busy

Behaviour:
- Reset values (async, sys_rst_n=0): state IDLE, row_cnt=0, out_wr_en=0, out_addr=0, out_data=0, drain_done=0, busy=0, overrun=0; shift_en=0 since state is IDLE.
- Reset mid-drain aborts immediately. Rows not yet drained are discarded. No drain_done is produced.
- States:
  - IDLE: cal_done=1 -> DRAIN, row_cnt<=0, busy<=1.
  - DRAIN: shift_en = out_ready. On each edge with out_ready=1:
    - out_wr_en<=1, out_data<=south_data, out_addr<=X-1-row_cnt, row_cnt<=row_cnt+1.
    - If row_cnt==X-1: also drain_done<=1, state<=IDLE, busy<=0.
  - On an edge with out_ready=0: out_wr_en<=0, nothing shifts, row_cnt holds.
- Latency: first out_wr_en appears 2 cycles after the cal_done edge when out_ready is held high (edge 1 enters DRAIN, edge 2 captures row). An X-row drain takes exactly X ready cycles.
- Row order: bottom PE row (index X-1) is presented first; out_addr therefore counts X-1 down to 0.
- out_wr_en and drain_done are deasserted (0) in every cycle not described above. out_data and out_addr hold their last value.
- row_cnt width is clog2(X+1); it never exceeds X-1.
- cal_done while busy=1 (including the final DRAIN cycle): ignored for sequencing; overrun<=1.
- overrun clears only on err_clr=1 or reset. If err_clr and a new overrun event occur in the same cycle, set wins.
- cal_done in IDLE with overrun=1 starts a drain normally.
- The edge that returns to IDLE ignores a cal_done; that cal_done counts as overrun. A drain must not start back-to-back without one IDLE cycle.

Test Plan:
- X=3,Y=3,DATA_W=16, out_ready=1: pulse cal_done with array model rows {0x0003..}, {0x0002..}, {0x0001..} presented bottom-first -> out_wr_en high 3 consecutive cycles starting 2 cycles after cal_done; out_addr 2,1,0; data matches; drain_done with 3rd write; busy low next cycle.
- Backpressure: out_ready pattern 1,0,0,1,0,1 during drain -> shift_en mirrors out_ready in DRAIN; exactly 3 writes, addresses 2,1,0; no shift or write in ready-low cycles; drain_done on the 6th DRAIN cycle.
- Overrun: second cal_done at the 2nd DRAIN cycle -> drain completes unaffected (3 writes); overrun=1 and stays 1; err_clr pulse -> overrun=0 next cycle; err_clr with simultaneous overrun event -> overrun stays 1.
- Reset mid-drain: assert sys_rst_n=0 after 1 write -> all outputs 0 immediately; after release, a new cal_done gives a full 3-row drain starting at addr 2.
- Back-to-back: cal_done on the final-write edge -> ignored, overrun=1; cal_done one cycle later in IDLE -> new drain starts correctly.
- Idle quiet: out_ready toggling with no cal_done -> shift_en, out_wr_en, and drain_done remain 0.
